// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - byte-serial W-bit operation sequencer driving an external 8-bit ALU
// Optional ALU_SEQ_ERR_EN: adds err output and rejects funcs other than add/and/or.
module alu_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            func,
   input  logic [8*NBYTES-1:0]   opA,
   input  logic [8*NBYTES-1:0]   opB,
   input  logic                  carryIn,
   output logic [7:0]            aluA,
   output logic [7:0]            aluB,
   output logic                  aluCarryIn,
   output logic [2:0]            aluFunc,
   input  logic [7:0]            aluResult,
   input  logic                  aluCarryOut,
   output logic [8*NBYTES-1:0]   result,
   output logic                  carryOut,
   output logic                  zero,
   output logic                  negetive,
   output logic                  busy,
   output logic                  done
`ifdef ALU_SEQ_ERR_EN
   ,output logic                 err
`endif
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [2:0]      r_func;
   logic            r_carry;
   logic [IW-1:0]   r_idx;
   logic [W-1:0]    r_result;
   logic            r_carry_out;
   logic            r_zero;
   logic            r_neg;

   logic            w_run;
   logic            w_last;
   logic            w_is_add;
   logic            w_bad_func;
   logic [W-1:0]    w_a_shift;
   logic [W-1:0]    w_b_shift;
   logic [W-1:0]    w_byte_mask;
   logic [W-1:0]    w_byte_ins;
   logic [W-1:0]    w_next_result;

`ifdef ALU_SEQ_ERR_EN
   logic            r_err;
   assign w_bad_func = (func != 3'b000) && (func != 3'b001) && (func != 3'b010);
   assign err        = r_err;
`else
   assign w_bad_func = 1'b0;
`endif

   assign w_run    = (r_state == S_RUN);
   assign w_last   = (r_idx == IW'(NBYTES - 1));
   assign w_is_add = (r_func == 3'b000);

   // Byte idx of the operands is brought down to bit 0 for the ALU drive.
   assign w_a_shift = r_a >> {r_idx, 3'b000};
   assign w_b_shift = r_b >> {r_idx, 3'b000};

   assign w_byte_mask   = W'(8'hFF) << {r_idx, 3'b000};
   assign w_byte_ins    = W'(aluResult) << {r_idx, 3'b000};
   assign w_next_result = (r_result & ~w_byte_mask) | w_byte_ins;

   assign aluA       = w_run ? w_a_shift[7:0] : 8'h00;
   assign aluB       = w_run ? w_b_shift[7:0] : 8'h00;
   assign aluFunc    = w_run ? r_func : 3'b000;
   assign aluCarryIn = w_run & w_is_add & r_carry;

   assign result   = r_result;
   assign carryOut = r_carry_out;
   assign zero     = r_zero;
   assign negetive = r_neg;
   assign busy     = w_run;
   assign done     = (r_state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = w_bad_func ? S_DONE : S_RUN;
         S_RUN:  if (w_last) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_func      <= 3'b000;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
`ifdef ALU_SEQ_ERR_EN
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= opA;
                  r_b      <= opB;
                  r_func   <= func;
                  r_carry  <= carryIn;
                  r_idx    <= '0;
                  r_result <= '0;
                  if (w_bad_func) begin
                     r_carry_out <= 1'b0;
                     r_zero      <= 1'b1;
                     r_neg       <= 1'b0;
                  end
`ifdef ALU_SEQ_ERR_EN
                  r_err    <= w_bad_func;
`endif
               end
            end
            S_RUN: begin
               r_result <= w_next_result;
               r_carry  <= aluCarryOut;
               r_idx    <= r_idx + 1'b1;
               // Flags come from the fully assembled value on the last byte edge.
               if (w_last) begin
                  r_carry_out <= w_is_add & aluCarryOut;
                  r_zero      <= (w_next_result == '0);
                  r_neg       <= w_next_result[W-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - table-driven bench for alu_seq_ctrl with a behavioural 8-bit ALU
module tb_alu_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  func;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        carryIn;
   logic [7:0]  aluA;
   logic [7:0]  aluB;
   logic        aluCarryIn;
   logic [2:0]  aluFunc;
   logic [7:0]  aluResult;
   logic        aluCarryOut;
   logic [31:0] result;
   logic        carryOut;
   logic        zero;
   logic        negetive;
   logic        busy;
   logic        done;
`ifdef ALU_SEQ_ERR_EN
   logic        err;
`endif

   int n_pass;
   int n_total;

   alu_seq_ctrl #(.NBYTES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func),
      .opA(opA), .opB(opB), .carryIn(carryIn),
      .aluA(aluA), .aluB(aluB), .aluCarryIn(aluCarryIn), .aluFunc(aluFunc),
      .aluResult(aluResult), .aluCarryOut(aluCarryOut),
      .result(result), .carryOut(carryOut), .zero(zero), .negetive(negetive),
      .busy(busy), .done(done)
`ifdef ALU_SEQ_ERR_EN
      , .err(err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 8-bit ALU
   always_comb begin
      aluResult   = 8'h00;
      aluCarryOut = 1'b0;
      case (aluFunc)
         3'b000: {aluCarryOut, aluResult} = {1'b0, aluA} + {1'b0, aluB} + 9'(aluCarryIn);
         3'b001: aluResult = aluA & aluB;
         3'b010: aluResult = aluA | aluB;
         default: aluResult = aluA ^ aluB;
      endcase
   end

   typedef struct {
      logic [2:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] res;
      logic        co;
      logic        z;
      logic        n;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic run_op(input string nm, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic [31:0] er,
                         input logic eco, input logic ez, input logic en, input int elat);
      int   n;
      logic cin_seen;
      @(negedge clk);
      start = 1'b1; func = fn; opA = a; opB = b; carryIn = c;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; func = 3'b000; opA = '0; opB = '0; carryIn = 1'b0;
      n = 0;
      cin_seen = 1'b0;
      while (!done && n < 20) begin
         if (busy && aluCarryIn) cin_seen = 1'b1;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({nm, " latency"}, n, elat);
      chk({nm, " result"}, result, er);
      chk({nm, " carryOut"}, {31'b0, carryOut}, {31'b0, eco});
      chk({nm, " zero"}, {31'b0, zero}, {31'b0, ez});
      chk({nm, " negetive"}, {31'b0, negetive}, {31'b0, en});
      if (fn != 3'b000) chk({nm, " aluCarryIn"}, {31'b0, cin_seen}, 32'd0);
      @(negedge clk);
      chk({nm, " done pulse"}, {31'b0, done}, 32'd0);
      chk({nm, " hold"}, result, er);
   endtask

   initial begin
      int dones;
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1; start = 1'b0; func = 3'b000; opA = '0; opB = '0; carryIn = 1'b0;

      vecs[0] = '{3'b000, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3'b000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{3'b010, 32'h12340000, 32'h00005678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{3'b000, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{3'b001, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{3'b000, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};

      @(negedge clk);
      @(negedge clk);
      chk("reset result", result, 32'd0);
      chk("reset flags", {27'b0, carryOut, zero, negetive, busy, done}, 32'd0);
      chk("reset alu drive", {12'b0, aluA, aluB, aluCarryIn, aluFunc}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].res, vecs[i].co, vecs[i].z, vecs[i].n, 4);
      end

      // start re-asserted on the second RUN cycle is ignored
      @(negedge clk);
      start = 1'b1; func = 3'b000; opA = 32'h000000FF; opB = 32'h00000001; carryIn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1; opA = 32'h55555555; opB = 32'h11111111; carryIn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("ignored start done count", dones, 1);
      chk("ignored start result", result, 32'h00000100);
      chk("ignored start busy", {31'b0, busy}, 32'd0);

      // reset on the third RUN cycle aborts with no done pulse
      @(negedge clk);
      start = 1'b1; func = 3'b000; opA = 32'hFFFFFFFF; opB = 32'h00000001; carryIn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre-abort busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort result", result, 32'd0);
      chk("abort flags", {27'b0, carryOut, zero, negetive, busy, done}, 32'd0);
      chk("abort alu drive", {12'b0, aluA, aluB, aluCarryIn, aluFunc}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort no done", dones, 0);
      run_op("post-abort", 3'b000, 32'h00000001, 32'h00000001, 1'b0,
             32'h00000002, 1'b0, 1'b0, 1'b0, 4);

`ifdef ALU_SEQ_ERR_EN
      chk("err idle", {31'b0, err}, 32'd0);
      run_op("bad func", 3'b111, 32'h12345678, 32'h9ABCDEF0, 1'b1,
             32'h00000000, 1'b0, 1'b1, 1'b0, 0);
      chk("err set", {31'b0, err}, 32'd1);
      run_op("good after err", 3'b010, 32'h0000000F, 32'h000000F0, 1'b0,
             32'h000000FF, 1'b0, 1'b0, 1'b0, 4);
      chk("err cleared", {31'b0, err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
